fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSN, default 32'h0000_0000, instruction word injected on flush (sll $0,$0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PC_hold  input  1  freeze PC this cycle (load-use or branch-operand stall).
REQ-006 IFID_hold  input  1  freeze IF/ID register this cycle.
REQ-007 branch_taken  input  1  ID-stage beq/bne resolved taken.
REQ-008 branch_target  input  32  branch destination address.
REQ-009 jump  input  1  ID-stage j/jal decoded.
REQ-010 jump_target  input  32  jump destination address.
REQ-011 imem_addr  output  32  instruction memory address, equals current PC.
REQ-012 imem_data  input  32  instruction word at imem_addr, combinational read.
REQ-013 pc_out  output  32  current PC register.
REQ-014 ifid_insn  output  32  IF/ID instruction.
REQ-015 ifid_pc4  output  32  IF/ID PC+4.
REQ-016 ifid_valid  output  1  IF/ID holds a real fetched instruction, not a bubble.
REQ-017 stall_count  output  16  saturating count of cycles with PC_hold=1.
REQ-018 flush_count  output  16  saturating count of redirects taken.

Function
REQ-019 redirect = (branch_taken | jump) & ~PC_hold; redirect SHALL be ignored while PC_hold=1, since ID operands are not yet valid.
REQ-020 Next PC priority SHALL be: PC_hold -> keep PC; else branch_taken -> branch_target; else jump -> jump_target; else PC+4.
REQ-021 Loaded PC bits [1:0] SHALL be forced to 2'b00; PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 IF/ID priority SHALL be: IFID_hold -> keep all fields; else redirect -> insn=NOP_INSN, pc4=0, valid=0; else insn=imem_data, pc4=PC+4, valid=1.
REQ-023 Fetch-to-IF/ID latency SHALL be one cycle; a redirect SHALL cost exactly one bubble.
REQ-024 PC_hold=1 with IFID_hold=0 SHALL load a bubble (valid=0, NOP_INSN) into IF/ID.
REQ-025 IFID_hold=1 with PC_hold=0 SHALL still advance PC (caller's responsibility; no internal check).
REQ-026 stall_count SHALL increment each cycle PC_hold=1, saturating at 16'hFFFF.
REQ-027 flush_count SHALL increment each cycle redirect=1, saturating at 16'hFFFF.
REQ-028 branch_taken and jump both high SHALL take branch_target and count one flush.

Reset
REQ-029 On reset=1 at a clock edge: PC=RESET_PC, ifid_insn=NOP_INSN, ifid_pc4=0, ifid_valid=0, both counters=0.
REQ-030 Reset SHALL override hold and redirect inputs in the same cycle.
REQ-031 Reset asserted mid-stall SHALL discard the stall; the first post-reset cycle fetches RESET_PC.

Structure
REQ-032 RESET_PC default, NOP_INSN, and the beq/bne/j/jal opcode constants SHALL live in the shared pipeline package.
REQ-033 The IF/ID register with hold/flush/valid SHALL be the sub-module if_id_reg, reused for later stage registers.
REQ-034 PC mux, PC register and counters SHALL stay in fetch_stage.

Verification
REQ-035 Reset, then 3 free cycles with imem returning 32'h8C01_0000 -> pc_out 0,4,8,12; ifid_pc4 4,8,12; valid=1.
REQ-036 PC=0x10, PC_hold=IFID_hold=1 for 2 cycles -> pc_out stays 0x10, IF/ID unchanged, stall_count=2.
REQ-037 PC=0x20, branch_taken=1, target 0x40 -> next pc_out=0x40, ifid_valid=0, ifid_insn=NOP_INSN, flush_count=1.
REQ-038 branch_taken=1 with PC_hold=1 -> PC unchanged, flush_count unchanged; branch re-asserted after hold releases -> redirect taken.
REQ-039 PC=32'hFFFF_FFFC, no hold -> pc_out=0; jump_target 32'h0000_0043 -> pc_out=32'h0000_0040.
REQ-040 stall_count preloaded near 16'hFFFF via long hold, then reset mid-hold -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline package: reset/NOP defaults, control-flow opcodes,
// the IF/ID payload layout and small helpers used by the fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

  localparam int COUNT_W = 16;

  // Opcode field [31:26] of the control-flow instructions decoded in ID.
  typedef enum logic [5:0] {
    OP_J   = 6'h02,
    OP_JAL = 6'h03,
    OP_BEQ = 6'h04,
    OP_BNE = 6'h05
  } opcodeT;

  // Payload carried by the IF/ID register.
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc4;
  } ifIdDataT;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] satInc(input logic [COUNT_W-1:0] cnt);
    return (cnt == {COUNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id.sv
// Generic pipeline stage register with hold, flush-to-bubble and a valid
// flag. Written for IF/ID but parameterised so later stages can reuse it.
module if_id_reg #(
  parameter int               WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             flush,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             valid
);

  // Hold beats flush, flush beats a normal load; reset beats everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut <= BUBBLE;
      valid   <= 1'b0;
    end else if (!hold) begin
      if (flush) begin
        dataOut <= BUBBLE;
        valid   <= 1'b0;
      end else begin
        dataOut <= dataIn;
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC selection and register, IF/ID stage
// register, and saturating stall/flush statistics counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PC_hold,
  input  logic         IFID_hold,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  input  logic         jump,
  input  logic [31:0]  jump_target,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_data,
  output logic [31:0]  pc_out,
  output logic [31:0]  ifid_insn,
  output logic [31:0]  ifid_pc4,
  output logic         ifid_valid,
  output logic [15:0]  stall_count,
  output logic [15:0]  flush_count
);

  localparam logic [63:0] IFID_BUBBLE = {NOP_INSN, 32'h0000_0000};

  logic [31:0]        pcReg;
  logic [31:0]        pcPlus4;
  logic [31:0]        nextPc;
  logic               redirect;
  ifIdDataT           ifIdIn;
  ifIdDataT           ifIdOut;
  logic [COUNT_W-1:0] stallCnt;
  logic [COUNT_W-1:0] flushCnt;

  // While the PC is frozen the ID operands are stale, so a branch or jump
  // seen in that cycle must not redirect fetch.
  assign redirect = (branch_taken | jump) & ~PC_hold;
  assign pcPlus4  = pcReg + 32'd4;

  // Next-PC mux: hold, then branch (wins over a simultaneous jump), then
  // jump, then sequential fetch.
  always_comb begin
    nextPc = pcReg;
    if (PC_hold) begin
      nextPc = pcReg;
    end else if (branch_taken) begin
      nextPc = alignPc(branch_target);
    end else if (jump) begin
      nextPc = alignPc(jump_target);
    end else begin
      nextPc = pcPlus4;
    end
  end

  // PC register; reset discards any pending stall or redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg <= alignPc(RESET_PC);
    end else begin
      pcReg <= nextPc;
    end
  end

  // Statistics: cycles spent stalled and redirects taken, both saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (PC_hold) begin
        stallCnt <= satInc(stallCnt);
      end
      if (redirect) begin
        flushCnt <= satInc(flushCnt);
      end
    end
  end

  assign ifIdIn.insn = imem_data;
  assign ifIdIn.pc4  = pcPlus4;

  // A stalled PC re-fetches the same word, so IF/ID takes a bubble instead
  // of duplicating it; a redirect squashes the wrong-path fetch likewise.
  if_id_reg #(
    .WIDTH  ($bits(ifIdDataT)),
    .BUBBLE (IFID_BUBBLE)
  ) ifIdReg (
    .clk     (clk),
    .reset   (reset),
    .hold    (IFID_hold),
    .flush   (redirect | PC_hold),
    .dataIn  (ifIdIn),
    .dataOut (ifIdOut),
    .valid   (ifid_valid)
  );

  assign imem_addr   = pcReg;
  assign pc_out      = pcReg;
  assign ifid_insn   = ifIdOut.insn;
  assign ifid_pc4    = ifIdOut.pc4;
  assign stall_count = stallCnt;
  assign flush_count = flushCnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard testbench for fetch_stage: the driver updates a behavioural
// model and queues the expected post-edge state; the monitor pops and
// compares after every rising edge.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] stall;
    logic [15:0] flush;
  } expectT;

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [31:0] FIXED_WORD = 32'h8C01_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PC_hold = 1'b0;
  logic        IFID_hold = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_out;
  logic [31:0] ifid_insn;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  int checks = 0;
  int errors = 0;
  bit fixedImem = 1'b1;

  expectT expQ[$];

  // Model state: what the fetch stage should hold after the last edge.
  longint mPc = 0;
  logic [31:0] mInsn = NOP;
  logic [31:0] mPc4 = 0;
  logic        mValid = 0;
  int          mStall = 0;
  int          mFlush = 0;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .PC_hold       (PC_hold),
    .IFID_hold     (IFID_hold),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pc_out        (pc_out),
    .ifid_insn     (ifid_insn),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (fixedImem) return FIXED_WORD;
    return {addr[15:0] ^ 16'h5A3C, ~addr[31:16]} + 32'h0101_0101;
  endfunction

  assign imem_data = memWord(imem_addr);

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the state the
  // design must show after the following rising edge.
  task automatic applyStimulus(input bit rst, input bit pch, input bit ifh,
                               input bit bt, input logic [31:0] btgt,
                               input bit j, input logic [31:0] jtgt);
    expectT e;
    bit     taken;
    longint seqPc;
    @(negedge clk);
    reset = rst; PC_hold = pch; IFID_hold = ifh;
    branch_taken = bt; branch_target = btgt; jump = j; jump_target = jtgt;
    if (rst) begin
      mPc = 0; mInsn = NOP; mPc4 = 0; mValid = 0; mStall = 0; mFlush = 0;
    end else begin
      taken = (bt || j) && !pch;
      seqPc = (mPc + 4) % 64'h1_0000_0000;
      if (!ifh) begin
        if (taken || pch) begin
          mInsn = NOP; mPc4 = 0; mValid = 0;
        end else begin
          mInsn = memWord(mPc[31:0]); mPc4 = seqPc[31:0]; mValid = 1;
        end
      end
      if (!pch) begin
        if (bt)      mPc = btgt - (btgt % 4);
        else if (j)  mPc = jtgt - (jtgt % 4);
        else         mPc = seqPc;
      end
      if (pch && mStall < 65535) mStall++;
      if (taken && mFlush < 65535) mFlush++;
    end
    e.pc = mPc[31:0]; e.insn = mInsn; e.pc4 = mPc4; e.valid = mValid;
    e.stall = mStall[15:0]; e.flush = mFlush[15:0];
    expQ.push_back(e);
  endtask

  task automatic freeCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Wait until just after the edge the last queued expectation refers to.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every output against the oldest queued expectation.
  initial begin
    expectT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc_out", pc_out, e.pc);
        checkOutput("imem_addr", imem_addr, e.pc);
        checkOutput("ifid_insn", ifid_insn, e.insn);
        checkOutput("ifid_pc4", ifid_pc4, e.pc4);
        checkOutput("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
        checkOutput("stall_count", {16'b0, stall_count}, {16'b0, e.stall});
        checkOutput("flush_count", {16'b0, flush_count}, {16'b0, e.flush});
      end
    end
  end

  // Directed scenarios, a random run, then saturation and reset-in-stall.
  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 32'h100, 1, 32'h200);
    settle();
    checkOutput("reset_pc", pc_out, 32'h0);
    checkOutput("reset_valid", {31'b0, ifid_valid}, 32'h0);

    for (int i = 1; i <= 3; i++) begin
      freeCycle();
      settle();
      checkOutput("seq_pc", pc_out, 32'(4 * i));
      checkOutput("seq_pc4", ifid_pc4, 32'(4 * i));
      checkOutput("seq_insn", ifid_insn, FIXED_WORD);
      checkOutput("seq_valid", {31'b0, ifid_valid}, 32'h1);
    end
    freeCycle();

    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0);
    settle();
    checkOutput("hold_pc", pc_out, 32'h10);
    checkOutput("hold_ifid_pc4", ifid_pc4, 32'h10);
    checkOutput("hold_stall_count", {16'b0, stall_count}, 32'd2);

    for (int i = 0; i < 4; i++) freeCycle();
    applyStimulus(0, 0, 0, 1, 32'h40, 0, 0);
    settle();
    checkOutput("branch_pc", pc_out, 32'h40);
    checkOutput("branch_valid", {31'b0, ifid_valid}, 32'h0);
    checkOutput("branch_insn", ifid_insn, NOP);
    checkOutput("branch_flush_count", {16'b0, flush_count}, 32'd1);

    applyStimulus(0, 1, 0, 1, 32'h80, 0, 0);
    settle();
    checkOutput("held_branch_pc", pc_out, 32'h40);
    checkOutput("held_branch_flush", {16'b0, flush_count}, 32'd1);
    applyStimulus(0, 0, 0, 1, 32'h80, 1, 32'h300);
    settle();
    checkOutput("released_branch_pc", pc_out, 32'h80);
    checkOutput("released_branch_flush", {16'b0, flush_count}, 32'd2);

    applyStimulus(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    freeCycle();
    settle();
    checkOutput("wrap_pc", pc_out, 32'h0);
    checkOutput("wrap_pc4", ifid_pc4, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0043);
    settle();
    checkOutput("align_pc", pc_out, 32'h40);

    fixedImem = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
                    $urandom, $urandom_range(0, 99) < 10, $urandom);
    end

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65537; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0);
    settle();
    checkOutput("stall_saturated", {16'b0, stall_count}, 32'h0000_FFFF);
    applyStimulus(1, 1, 1, 1, 32'h500, 0, 0);
    settle();
    checkOutput("midstall_reset_pc", pc_out, 32'h0);
    checkOutput("midstall_reset_stall", {16'b0, stall_count}, 32'h0);
    checkOutput("midstall_reset_insn", ifid_insn, NOP);
    freeCycle();
    settle();
    checkOutput("post_reset_pc4", ifid_pc4, 32'h4);
    checkOutput("post_reset_insn", ifid_insn, memWord(32'h0));
    checkOutput("post_reset_valid", {31'b0, ifid_valid}, 32'h1);

    repeat (3) @(posedge clk);
    #3;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
